// File: rtl/vision_frame_classifier.sv
// vision_frame_classifier
//   Producer end of the vision-data interface, clocked in the camera pixel
//   domain. It consumes the thresholded mask stream (one bit per active
//   pixel) and accumulates per-frame statistics: pixel count, coordinate
//   sums and a 3x3 grid of cell counts. Once per frame it classifies them
//   into a lane, a jump flag and a 3x3 occupancy map. It then raises
//   vision_data_valid for VALID_HOLD pixel clocks, which is long enough for
//   the 2-flop synchronizers in the system clock domain to catch it.
//
//   Optional build macro: VISION_LANE_HYST_EN. When it is defined, lane
//   hysteresis is enabled: a new lane is adopted only after two
//   consecutive published frames agree on it.
//
// Ports
//   pixel_clock_in     in   camera pixel clock
//   system_reset       in   asynchronous, active-high reset
//   hcount[10:0]       in   pixel column
//   vcount[9:0]        in   pixel row
//   pixel_valid        in   hcount/vcount/mask_bit valid this cycle
//   mask_bit           in   pixel matches player colour
//   lane[1:0]          out  00 left, 01 middle, 10 right
//   jump               out  player centroid above JUMP_ROW
//   quadrants[8:0]     out  bit (row*3+col) set when the cell is occupied
//   vision_data_valid  out  publish strobe, high VALID_HOLD cycles

module vision_frame_classifier #(
  parameter int H_ACTIVE         = 320,
  parameter int V_ACTIVE         = 240,
  parameter int MIN_CELL_PIXELS  = 64,
  parameter int MIN_TOTAL_PIXELS = 256,
  parameter int JUMP_ROW         = 80,
  parameter int VALID_HOLD       = 8
) (
  input  logic        pixel_clock_in,
  input  logic        system_reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        pixel_valid,
  input  logic        mask_bit,
  output logic [1:0]  lane,
  output logic        jump,
  output logic [8:0]  quadrants,
  output logic        vision_data_valid
);

  localparam logic [10:0] H_MAX     = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST    = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_T1      = 11'(H_ACTIVE / 3);
  localparam logic [10:0] H_T2      = 11'(2 * H_ACTIVE / 3);
  localparam logic [9:0]  V_MAX     = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_T1      = 10'(V_ACTIVE / 3);
  localparam logic [9:0]  V_T2      = 10'(2 * V_ACTIVE / 3);
  localparam logic [25:0] CX_T1     = 26'(H_ACTIVE / 3);
  localparam logic [25:0] CX_T2     = 26'(2 * H_ACTIVE / 3);
  localparam logic [25:0] CY_JUMP   = 26'(JUMP_ROW);
  localparam logic [16:0] CELL_MIN  = 17'(MIN_CELL_PIXELS);
  localparam logic [16:0] TOTAL_MIN = 17'(MIN_TOTAL_PIXELS);
  localparam logic [7:0]  DIV_LAST  = 8'd25;
  localparam logic [7:0]  HOLD_LAST = 8'(VALID_HOLD - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, DECIDE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [16:0] total_q, total_d;
  logic [25:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [16:0] cell_q [9];
  logic [16:0] cell_d [9];
  logic [16:0] snap_total_q, snap_total_d;
  logic [25:0] snap_sum_x_q, snap_sum_x_d, snap_sum_y_q, snap_sum_y_d;
  logic [16:0] snap_cell_q [9];
  logic [16:0] snap_cell_d [9];
  logic        frame_end_q, frame_end_d;
  logic        snap_pend_q, snap_pend_d;
  logic        no_player_q, no_player_d;
  logic [8:0]  occ_q, occ_d;
  logic [25:0] num_x_q, num_x_d, num_y_q, num_y_d;
  logic [16:0] rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [16:0] den_q, den_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic        jump_q, jump_d;
  logic [8:0]  quad_q, quad_d;
  logic        valid_q, valid_d;
`ifdef VISION_LANE_HYST_EN
  logic [1:0]  cand_q, cand_d;
  logic        cand_valid_q, cand_valid_d;
`endif

  logic        accept;
  logic [1:0]  row, col;
  logic [3:0]  cell_idx;
  logic [1:0]  lane_new;
  logic [42:0] step_x, step_y;

  // One restoring-division step: shift the next dividend bit into the
  // remainder, subtract when possible, and shift the quotient bit in from
  // the right. The remainder stays below the divisor, so 17 bits are enough.
  function automatic logic [42:0] div_step(input logic [16:0] rem,
                                           input logic [25:0] num,
                                           input logic [16:0] den);
    logic [17:0] rem_sh;
    logic [16:0] rem_new;
    logic        qbit;
    rem_sh = {rem, num[25]};
    qbit   = (rem_sh >= {1'b0, den});
    rem_new = qbit ? 17'(rem_sh - {1'b0, den}) : rem_sh[16:0];
    return {rem_new, num[24:0], qbit};
  endfunction

  // Decode the grid cell of the current pixel and decide whether the pixel
  // counts. Blanking coordinates are rejected even when pixel_valid is high.
  always_comb begin
    accept   = pixel_valid && (hcount < H_MAX) && (vcount < V_MAX);
    col      = (hcount < H_T1) ? 2'd0 : (hcount < H_T2) ? 2'd1 : 2'd2;
    row      = (vcount < V_T1) ? 2'd0 : (vcount < V_T2) ? 2'd1 : 2'd2;
    cell_idx = 4'(row) * 4'd3 + 4'(col);
    lane_new = (num_x_q < CX_T1) ? 2'b00 : (num_x_q < CX_T2) ? 2'b01 : 2'b10;
    step_x   = div_step(rem_x_q, num_x_q, den_q);
    step_y   = div_step(rem_y_q, num_y_q, den_q);
  end

  // Accumulators and the snapshot. On the cycle after the frame-end pixel the
  // live sums move into the snapshot and restart from zero. A pixel arriving
  // in that same cycle already belongs to the new frame. The snapshot is
  // always overwritten; the FSM decides whether anyone looks at it.
  always_comb begin
    frame_end_d  = accept && (hcount == H_LAST) && (vcount == V_LAST);
    snap_pend_d  = frame_end_q;
    snap_total_d = frame_end_q ? total_q : snap_total_q;
    snap_sum_x_d = frame_end_q ? sum_x_q : snap_sum_x_q;
    snap_sum_y_d = frame_end_q ? sum_y_q : snap_sum_y_q;
    total_d      = frame_end_q ? 17'd0 : total_q;
    sum_x_d      = frame_end_q ? 26'd0 : sum_x_q;
    sum_y_d      = frame_end_q ? 26'd0 : sum_y_q;
    for (int i = 0; i < 9; i++) begin
      snap_cell_d[i] = frame_end_q ? cell_q[i] : snap_cell_q[i];
      cell_d[i]      = frame_end_q ? 17'd0 : cell_q[i];
    end
    if (accept && mask_bit) begin
      total_d = total_d + 17'd1;
      sum_x_d = sum_x_d + 26'(hcount);
      sum_y_d = sum_y_d + 26'(vcount);
      for (int i = 0; i < 9; i++) begin
        if (cell_idx == 4'(i)) begin
          cell_d[i] = cell_d[i] + 17'd1;
        end
      end
    end
  end

  // Classification FSM. IDLE latches what it needs from the snapshot
  // (occupancy, no_player flag, divider operands). This keeps an overrun
  // snapshot landing during DIVIDE from corrupting the frame in flight.
  always_comb begin
    state_d     = state_q;
    no_player_d = no_player_q;
    occ_d       = occ_q;
    num_x_d     = num_x_q;
    num_y_d     = num_y_q;
    rem_x_d     = rem_x_q;
    rem_y_d     = rem_y_q;
    den_d       = den_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    jump_d      = jump_q;
    quad_d      = quad_q;
    valid_d     = (state_q == HOLD);
`ifdef VISION_LANE_HYST_EN
    cand_d       = cand_q;
    cand_valid_d = cand_valid_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (snap_pend_q) begin
          no_player_d = (snap_total_q < TOTAL_MIN);
          for (int i = 0; i < 9; i++) begin
            occ_d[i] = (snap_cell_q[i] >= CELL_MIN);
          end
          num_x_d = snap_sum_x_q;
          num_y_d = snap_sum_y_q;
          rem_x_d = 17'd0;
          rem_y_d = 17'd0;
          den_d   = snap_total_q;
          cnt_d   = 8'd0;
          state_d = (snap_total_q < TOTAL_MIN) ? DECIDE : DIVIDE;
        end
      end
      DIVIDE: begin
        {rem_x_d, num_x_d} = step_x;
        {rem_y_d, num_y_d} = step_y;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == DIV_LAST) begin
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        quad_d  = no_player_q ? 9'd0 : occ_q;
        jump_d  = !no_player_q && (num_y_q < CY_JUMP);
`ifdef VISION_LANE_HYST_EN
        if (no_player_q || (lane_new == lane_q)) begin
          cand_valid_d = 1'b0;
        end else if (cand_valid_q && (cand_q == lane_new)) begin
          lane_d       = lane_new;
          cand_valid_d = 1'b0;
        end else begin
          cand_d       = lane_new;
          cand_valid_d = 1'b1;
        end
`else
        if (!no_player_q) begin
          lane_d = lane_new;
        end
`endif
        cnt_d   = 8'd0;
        state_d = HOLD;
      end
      HOLD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset throws away the partial frame and any publish in
  // progress, and pulls the valid strobe low at once.
  always_ff @(posedge pixel_clock_in or posedge system_reset) begin
    if (system_reset) begin
      state_q      <= IDLE;
      total_q      <= '0;
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      snap_total_q <= '0;
      snap_sum_x_q <= '0;
      snap_sum_y_q <= '0;
      for (int i = 0; i < 9; i++) begin
        cell_q[i]      <= '0;
        snap_cell_q[i] <= '0;
      end
      frame_end_q  <= 1'b0;
      snap_pend_q  <= 1'b0;
      no_player_q  <= 1'b0;
      occ_q        <= '0;
      num_x_q      <= '0;
      num_y_q      <= '0;
      rem_x_q      <= '0;
      rem_y_q      <= '0;
      den_q        <= '0;
      cnt_q        <= '0;
      lane_q       <= 2'b01;
      jump_q       <= 1'b0;
      quad_q       <= '0;
      valid_q      <= 1'b0;
`ifdef VISION_LANE_HYST_EN
      cand_q       <= 2'b00;
      cand_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      sum_x_q      <= sum_x_d;
      sum_y_q      <= sum_y_d;
      snap_total_q <= snap_total_d;
      snap_sum_x_q <= snap_sum_x_d;
      snap_sum_y_q <= snap_sum_y_d;
      for (int i = 0; i < 9; i++) begin
        cell_q[i]      <= cell_d[i];
        snap_cell_q[i] <= snap_cell_d[i];
      end
      frame_end_q  <= frame_end_d;
      snap_pend_q  <= snap_pend_d;
      no_player_q  <= no_player_d;
      occ_q        <= occ_d;
      num_x_q      <= num_x_d;
      num_y_q      <= num_y_d;
      rem_x_q      <= rem_x_d;
      rem_y_q      <= rem_y_d;
      den_q        <= den_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      jump_q       <= jump_d;
      quad_q       <= quad_d;
      valid_q      <= valid_d;
`ifdef VISION_LANE_HYST_EN
      cand_q       <= cand_d;
      cand_valid_q <= cand_valid_d;
`endif
    end
  end

  assign lane              = lane_q;
  assign jump              = jump_q;
  assign quadrants         = quad_q;
  assign vision_data_valid = valid_q;

endmodule

// File: tb/tb_vision_frame_classifier.sv
// tb_vision_frame_classifier
//   Bench for vision_frame_classifier on a small 12x9 frame. Each frame is an
//   axis-aligned mask rectangle. A short table of frames covers the main
//   classification cases. Hand-written sequences then cover overrun, reset
//   during division and reset during the valid pulse. Lane expectations come
//   from a small reference model that follows the build's hysteresis setting.

module tb_vision_frame_classifier;

  logic        clk;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        pixel_valid;
  logic        mask_bit;
  logic [1:0]  lane;
  logic        jump;
  logic [8:0]  quadrants;
  logic        valid;

  int passCount;
  int checkCount;
  int modelLane;
  int modelCand;
  int modelCandValid;

  typedef struct {
    int hLo;
    int hHi;
    int vLo;
    int vHi;
    int expLat;
    int noPlayer;
    int rawLane;
    int expJump;
    int expQuad;
  } vec_t;

  vec_t vecs[7];

  vision_frame_classifier #(
    .H_ACTIVE(12), .V_ACTIVE(9), .MIN_CELL_PIXELS(4),
    .MIN_TOTAL_PIXELS(4), .JUMP_ROW(3), .VALID_HOLD(4)
  ) dut (
    .pixel_clock_in(clk),
    .system_reset(rst),
    .hcount(hcount),
    .vcount(vcount),
    .pixel_valid(pixel_valid),
    .mask_bit(mask_bit),
    .lane(lane),
    .jump(jump),
    .quadrants(quadrants),
    .vision_data_valid(valid)
  );

  // Free-running pixel clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and keep the counts.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference lane behaviour for one published frame.
  task automatic modelPublish(input int noPlayer, input int raw);
`ifdef VISION_LANE_HYST_EN
    if (noPlayer != 0 || raw == modelLane) begin
      modelCandValid = 0;
    end else if (modelCandValid != 0 && modelCand == raw) begin
      modelLane      = raw;
      modelCandValid = 0;
    end else begin
      modelCand      = raw;
      modelCandValid = 1;
    end
`else
    if (noPlayer == 0) modelLane = raw;
`endif
  endtask

  task automatic modelReset();
    modelLane      = 1;
    modelCand      = 0;
    modelCandValid = 0;
  endtask

  // Stream one full frame with the given mask rectangle. Every line is
  // preceded by a masked blanking pixel (hcount out of range) and a masked
  // pixel with pixel_valid low; both must be ignored. Returns on the
  // falling edge right after the frame-end pixel was clocked in.
  task automatic applyStimulus(input int hLo, input int hHi, input int vLo, input int vHi);
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      pixel_valid = 1'b1; hcount = 11'd12; vcount = 10'(v); mask_bit = 1'b1;
      @(negedge clk);
      pixel_valid = 1'b0; hcount = 11'd0; vcount = 10'd0; mask_bit = 1'b1;
      for (int h = 0; h < 12; h++) begin
        @(negedge clk);
        pixel_valid = 1'b1;
        hcount      = 11'(h);
        vcount      = 10'(v);
        mask_bit    = (h >= hLo && h <= hHi && v >= vLo && v <= vHi);
      end
    end
    @(negedge clk);
    pixel_valid = 1'b0; mask_bit = 1'b0;
  endtask

  // Count cycles from the frame end to the valid rise, then measure the
  // pulse width. Both waits are bounded.
  task automatic measurePulse(output int lat, output int width);
    lat = 0;
    while (!valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    width = 0;
    while (valid && width < 20) begin
      width++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int width;
    int first;
    int highs;
    int sLane;
    int sJump;
    int sQuad;

    passCount = 0;
    checkCount = 0;
    modelReset();
    rst = 1'b1; pixel_valid = 1'b0; mask_bit = 1'b0; hcount = '0; vcount = '0;

    //             hLo hHi vLo vHi lat np raw jump quad
    vecs[0] = '{ 1,  0,  0,  0,  4, 1, 0, 0, 'h000 };
    vecs[1] = '{ 0,  3,  6,  8, 30, 0, 0, 0, 'h040 };
    vecs[2] = '{ 8, 11,  0,  2, 30, 0, 2, 1, 'h004 };
    vecs[3] = '{ 4,  6,  3,  3,  4, 1, 0, 0, 'h000 };
    vecs[4] = '{ 4,  7,  3,  3, 30, 0, 1, 0, 'h010 };
    vecs[5] = '{ 0,  3,  3,  5, 30, 0, 0, 0, 'h008 };
    vecs[6] = '{ 0,  3,  3,  5, 30, 0, 0, 0, 'h008 };

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset lane", int'(lane), 1);
    checkOutput("reset jump", int'(jump), 0);
    checkOutput("reset quadrants", int'(quadrants), 0);
    checkOutput("reset valid", int'(valid), 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].hLo, vecs[i].hHi, vecs[i].vLo, vecs[i].vHi);
      measurePulse(lat, width);
      modelPublish(vecs[i].noPlayer, vecs[i].rawLane);
      checkOutput($sformatf("v%0d latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("v%0d valid width", i), width, 4);
      checkOutput($sformatf("v%0d lane", i), int'(lane), modelLane);
      checkOutput($sformatf("v%0d jump", i), int'(jump), vecs[i].expJump);
      checkOutput($sformatf("v%0d quadrants", i), int'(quadrants), vecs[i].expQuad);
    end

    // Overrun: a second frame end arrives 10 cycles later, during DIVIDE.
    // Only the first frame may be published.
    applyStimulus(8, 11, 0, 2);
    first = -1; highs = 0; sLane = -1; sJump = -1; sQuad = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 9) begin
        pixel_valid = 1'b1; hcount = 11'd11; vcount = 10'd8; mask_bit = 1'b1;
      end
      if (i == 10) begin
        pixel_valid = 1'b0; mask_bit = 1'b0;
      end
      if (valid) begin
        if (first < 0) begin
          first = i; sLane = int'(lane); sJump = int'(jump); sQuad = int'(quadrants);
        end
        highs++;
      end
    end
    modelPublish(0, 2);
    checkOutput("overrun latency", first, 30);
    checkOutput("overrun valid cycles", highs, 4);
    checkOutput("overrun lane", sLane, modelLane);
    checkOutput("overrun jump", sJump, 1);
    checkOutput("overrun quadrants", sQuad, 'h004);

    // Reset while the divider is busy: outputs return at once, and the
    // abandoned frame never publishes.
    applyStimulus(0, 3, 6, 8);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("mid-divide reset lane", int'(lane), 1);
    checkOutput("mid-divide reset quadrants", int'(quadrants), 0);
    checkOutput("mid-divide reset jump", int'(jump), 0);
    checkOutput("mid-divide reset valid", int'(valid), 0);
    @(negedge clk);
    rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid) highs++;
    end
    checkOutput("abandoned frame valid cycles", highs, 0);

    applyStimulus(0, 3, 6, 8);
    measurePulse(lat, width);
    modelPublish(0, 0);
    checkOutput("post-reset latency", lat, 30);
    checkOutput("post-reset valid width", width, 4);
    checkOutput("post-reset lane", int'(lane), modelLane);
    checkOutput("post-reset quadrants", int'(quadrants), 'h040);

    // Reset while the valid strobe is high drops it asynchronously.
    applyStimulus(0, 3, 6, 8);
    lat = 0;
    while (!valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("hold-reset latency", lat, 30);
    rst = 1'b1;
    #1;
    checkOutput("hold-reset valid", int'(valid), 0);
    checkOutput("hold-reset lane", int'(lane), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
